timer_counter: RTL and testbench
================================

# timer_counter

64-bit up-counter, compare and interrupt stage of the timer, directly downstream of the counter-control stage. It advances the count by one on every cycle the upstream `cnt_en` is high and compares the count against a software-programmed 64-bit compare value. A match sets a sticky interrupt status, which is gated by an enable to drive the timer interrupt. Both 64-bit registers are written in 32-bit halves by the register-decode block.

## Interface
Parameters:
- CMP_RST_VAL, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the compare register

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- cnt_en  in  1  count-enable pulse/level from counter control (already halt-gated)
- timer_en  in  1  timer enable bit from control register
- wdata  in  32  register write data
- cnt_lo_wr  in  1  write wdata to cnt_val[31:0]
- cnt_hi_wr  in  1  write wdata to cnt_val[63:32]
- cmp_lo_wr  in  1  write wdata to cmp_val[31:0]
- cmp_hi_wr  in  1  write wdata to cmp_val[63:32]
- int_st_clr  in  1  write-1-to-clear strobe for int_st
- int_en  in  1  interrupt enable bit
- cnt_val  out  64  current count
- cmp_val  out  64  current compare value
- int_st  out  1  sticky interrupt status
- tim_int  out  1  interrupt output, equal to int_st & int_en

## Operation
- **Reset values:**
  - cnt_val = 0
  - cmp_val = CMP_RST_VAL
  - int_st = 0
  - tim_int = 0
  - internal timer_en_d = 0
- **Counter next-state priority, highest first:**
  1. timer_en falling edge (timer_en_d=1, timer_en=0): clear cnt_val to 0. This overrides writes in the same cycle.
  2. Software half-writes: the written half takes wdata.
     - The unwritten half takes its normal next value: the incremented value if cnt_en, else hold.
     - The increment is computed on the full pre-write 64-bit value, including carry from lo into hi.
     - lo and hi writes may occur in the same cycle; both halves then take wdata.
  3. cnt_en=1: cnt_val <= cnt_val + 1, modulo 2^64.
  4. Otherwise: hold.
- **Wrap-around:** 64'hFFFF_FFFF_FFFF_FFFF + 1 = 0. No overflow flag.
- Counter writes are accepted regardless of timer_en.
- **Compare register:**
  - Updated only by cmp_lo_wr / cmp_hi_wr, per half.
  - Never modified by hardware.
- **Match:** match = (cnt_val == cmp_val), a combinational full 64-bit equality on the registered values.
- **Interrupt status:**
  - int_st <= 1 when match.
  - Else int_st <= 0 when int_st_clr.
  - Else hold.
  - Set wins over a simultaneous clear.
  - int_st persists while match persists, e.g. when counting is stopped on the match value.
- **Interrupt output:**
  - tim_int = int_st & int_en, combinational from registers.
  - Disabling int_en masks the output but does not clear int_st.
- timer_en_d is a 1-cycle registered copy of timer_en, used for edge detection only.

## Timing
- cnt_en sampled high at edge N: cnt_val shows the incremented value after edge N.
- A write strobe at edge N: the new half is visible after edge N.
- cnt_val reaches cmp_val after edge N: match is high in cycle N+1, and int_st/tim_int rise after edge N+1. Latency is one cycle from count to status.
- A compare write that creates equality with a held count behaves the same way: int_st sets one edge after the write.
- int_st_clr at edge N with no match: int_st is low after edge N.
- timer_en 1→0 seen at edge N: cnt_val = 0 after edge N.
- Re-enable does not clear cnt_val.
- Asynchronous reset mid-count forces all reset values immediately. Counting resumes from 0 on the first cnt_en after reset deasserts.
- No back-pressure. All strobes are single-cycle and level-insensitive beyond the sampled edge.

## Test plan
- **Reset then count:** reset, cnt_en held high 10 cycles.
  - Expect cnt_val = 10.
  - Expect cmp_val = FFFF_FFFF_FFFF_FFFF.
  - Expect int_st = 0.
- **Lo-to-hi carry and wrap:**
  - Write cnt_lo = FFFF_FFFE and cnt_hi = 0, then pulse cnt_en 3 times. Expect cnt_val = 0000_0001_0000_0001.
  - Write both halves to all-ones, pulse cnt_en once. Expect cnt_val = 0.
- **Compare and interrupt:**
  - Program cmp = 5, int_en=1, cnt_en high. Expect int_st and tim_int to rise the cycle after cnt_val = 5.
  - Set int_en=0: tim_int = 0 while int_st = 1.
  - Pulse int_st_clr once the count is past 5: int_st = 0.
- **Set-vs-clear collision:** stop counting at cnt_val == cmp_val, pulse int_st_clr. Expect int_st to remain 1.
- **Write/increment collision:** cnt_val = 0000_0000_FFFF_FFFF, cnt_lo_wr with wdata = 0000_0010 and cnt_en=1 in the same cycle. Expect cnt_val = 0000_0001_0000_0010.
- **Disable clear and reset mid-operation:**
  - Count to 20, drop timer_en: cnt_val = 0 next cycle.
  - Simultaneous cnt_hi_wr on that edge is ignored.
  - Assert sys_rst_n low asynchronously mid-count: all outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: 64-bit up-counter with a software-programmable 64-bit compare
// value and a sticky match interrupt. Both 64-bit registers are written in
// 32-bit halves. A falling edge of timer_en clears the count.
module timer_counter #(
  parameter logic [63:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cnt_en,
  input  logic        timer_en,
  input  logic [31:0] wdata,
  input  logic        cnt_lo_wr,
  input  logic        cnt_hi_wr,
  input  logic        cmp_lo_wr,
  input  logic        cmp_hi_wr,
  input  logic        int_st_clr,
  input  logic        int_en,
  output logic [63:0] cnt_val,
  output logic [63:0] cmp_val,
  output logic        int_st,
  output logic        tim_int
);

  logic [63:0] r_cnt;
  logic [63:0] r_cmp;
  logic        r_int_st;
  logic        r_timer_en_d;

  logic [63:0] w_cnt_norm;
  logic [63:0] w_cnt_nxt;
  logic [63:0] w_cmp_nxt;
  logic        w_fall;
  logic        w_match;
  logic        w_int_st_nxt;

  // Falling edge of timer_en and full-width equality on registered values.
  assign w_fall  = r_timer_en_d & ~timer_en;
  assign w_match = (r_cnt == r_cmp);

  // Normal next count: increment (carry across halves) when enabled, else hold.
  always_comb begin
    w_cnt_norm = r_cnt;
    if (cnt_en) begin
      w_cnt_norm = r_cnt + 64'd1;
    end else begin
      w_cnt_norm = r_cnt;
    end
  end

  // Counter next state: disable-clear beats half-writes, which override only
  // the written half of the normal next value.
  always_comb begin
    w_cnt_nxt = w_cnt_norm;
    if (w_fall) begin
      w_cnt_nxt = 64'd0;
    end else begin
      w_cnt_nxt[31:0]  = cnt_lo_wr ? wdata : w_cnt_norm[31:0];
      w_cnt_nxt[63:32] = cnt_hi_wr ? wdata : w_cnt_norm[63:32];
    end
  end

  // Compare next state: only software half-writes change it.
  always_comb begin
    w_cmp_nxt = r_cmp;
    w_cmp_nxt[31:0]  = cmp_lo_wr ? wdata : r_cmp[31:0];
    w_cmp_nxt[63:32] = cmp_hi_wr ? wdata : r_cmp[63:32];
  end

  // Sticky status: a match sets it and wins over a simultaneous clear.
  always_comb begin
    w_int_st_nxt = r_int_st;
    if (w_match) begin
      w_int_st_nxt = 1'b1;
    end else if (int_st_clr) begin
      w_int_st_nxt = 1'b0;
    end else begin
      w_int_st_nxt = r_int_st;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt        <= 64'd0;
      r_cmp        <= CMP_RST_VAL;
      r_int_st     <= 1'b0;
      r_timer_en_d <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_cmp        <= w_cmp_nxt;
      r_int_st     <= w_int_st_nxt;
      r_timer_en_d <= timer_en;
    end
  end

  assign cnt_val = r_cnt;
  assign cmp_val = r_cmp;
  assign int_st  = r_int_st;
  assign tim_int = r_int_st & int_en;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        cnt_en;
  logic        timer_en;
  logic [31:0] wdata;
  logic        cnt_lo_wr;
  logic        cnt_hi_wr;
  logic        cmp_lo_wr;
  logic        cmp_hi_wr;
  logic        int_st_clr;
  logic        int_en;
  logic [63:0] cnt_val;
  logic [63:0] cmp_val;
  logic        int_st;
  logic        tim_int;

  int errors = 0;
  int checks = 0;

  timer_counter dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cnt_en     (cnt_en),
    .timer_en   (timer_en),
    .wdata      (wdata),
    .cnt_lo_wr  (cnt_lo_wr),
    .cnt_hi_wr  (cnt_hi_wr),
    .cmp_lo_wr  (cmp_lo_wr),
    .cmp_hi_wr  (cmp_hi_wr),
    .int_st_clr (int_st_clr),
    .int_en     (int_en),
    .cnt_val    (cnt_val),
    .cmp_val    (cmp_val),
    .int_st     (int_st),
    .tim_int    (tim_int)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    cnt_en     = 1'b0;
    timer_en   = 1'b1;
    wdata      = 32'd0;
    cnt_lo_wr  = 1'b0;
    cnt_hi_wr  = 1'b0;
    cmp_lo_wr  = 1'b0;
    cmp_hi_wr  = 1'b0;
    int_st_clr = 1'b0;
    int_en     = 1'b0;

    // Reset state
    #12;
    check("rst_cnt", cnt_val, 64'd0);
    check("rst_cmp", cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_int_st", {63'd0, int_st}, 64'd0);
    check("rst_tim_int", {63'd0, tim_int}, 64'd0);
    sys_rst_n = 1'b1;

    // Count 10 cycles
    cnt_en = 1'b1;
    repeat (10) tick();
    check("count10", cnt_val, 64'd10);
    check("count10_cmp", cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("count10_int_st", {63'd0, int_st}, 64'd0);

    // Lo-to-hi carry
    cnt_en = 1'b0;
    cnt_lo_wr = 1'b1; wdata = 32'hFFFF_FFFE; tick();
    cnt_lo_wr = 1'b0; cnt_hi_wr = 1'b1; wdata = 32'h0000_0000; tick();
    cnt_hi_wr = 1'b0;
    check("half_writes", cnt_val, 64'h0000_0000_FFFF_FFFE);
    cnt_en = 1'b1;
    repeat (3) tick();
    cnt_en = 1'b0;
    check("carry", cnt_val, 64'h0000_0001_0000_0001);

    // Wrap-around; all-ones also equals the reset compare value
    cnt_lo_wr = 1'b1; cnt_hi_wr = 1'b1; wdata = 32'hFFFF_FFFF; tick();
    cnt_lo_wr = 1'b0; cnt_hi_wr = 1'b0;
    check("all_ones", cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
    cnt_en = 1'b1; tick(); cnt_en = 1'b0;
    check("wrap", cnt_val, 64'd0);
    check("wrap_match_int_st", {63'd0, int_st}, 64'd1);
    check("wrap_masked_tim_int", {63'd0, tim_int}, 64'd0);
    int_st_clr = 1'b1; tick(); int_st_clr = 1'b0;
    check("clr_no_match", {63'd0, int_st}, 64'd0);

    // Compare = 5, interrupt enabled
    cmp_lo_wr = 1'b1; wdata = 32'd5; tick();
    cmp_lo_wr = 1'b0;
    check("cmp_lo_only", cmp_val, 64'hFFFF_FFFF_0000_0005);
    cmp_hi_wr = 1'b1; wdata = 32'd0; tick();
    cmp_hi_wr = 1'b0;
    check("cmp5", cmp_val, 64'd5);
    int_en = 1'b1;
    cnt_en = 1'b1;
    repeat (5) tick();
    check("cnt_at5", cnt_val, 64'd5);
    check("int_st_before", {63'd0, int_st}, 64'd0);
    tick();
    check("cnt_at6", cnt_val, 64'd6);
    check("int_st_rise", {63'd0, int_st}, 64'd1);
    check("tim_int_rise", {63'd0, tim_int}, 64'd1);
    int_en = 1'b0;
    #1;
    check("mask_tim_int", {63'd0, tim_int}, 64'd0);
    check("mask_keeps_st", {63'd0, int_st}, 64'd1);
    tick();
    int_st_clr = 1'b1; tick(); int_st_clr = 1'b0;
    check("clr_cnt", cnt_val, 64'd8);
    check("clr_past", {63'd0, int_st}, 64'd0);

    // Set-vs-clear collision with count held at compare value
    cnt_en = 1'b0;
    cnt_lo_wr = 1'b1; wdata = 32'd5; tick(); cnt_lo_wr = 1'b0;
    check("held_at5", cnt_val, 64'd5);
    check("cmp_write_no_st_yet", {63'd0, int_st}, 64'd0);
    tick();
    check("held_st_set", {63'd0, int_st}, 64'd1);
    int_st_clr = 1'b1; tick(); int_st_clr = 1'b0;
    check("set_beats_clr", {63'd0, int_st}, 64'd1);

    // Write/increment collision
    cnt_lo_wr = 1'b1; wdata = 32'hFFFF_FFFF; tick();
    check("pre_collide", cnt_val, 64'h0000_0000_FFFF_FFFF);
    wdata = 32'h0000_0010; cnt_en = 1'b1; tick();
    cnt_lo_wr = 1'b0; cnt_en = 1'b0;
    check("wr_inc_collide", cnt_val, 64'h0000_0001_0000_0010);

    // Disable clear
    cnt_lo_wr = 1'b1; cnt_hi_wr = 1'b1; wdata = 32'd0; tick();
    cnt_lo_wr = 1'b0; cnt_hi_wr = 1'b0;
    cnt_en = 1'b1;
    repeat (20) tick();
    check("count20", cnt_val, 64'd20);
    timer_en = 1'b0; cnt_hi_wr = 1'b1; wdata = 32'h0000_1234; tick();
    cnt_hi_wr = 1'b0;
    check("disable_clear", cnt_val, 64'd0);
    tick();
    check("disabled_count", cnt_val, 64'd1);
    timer_en = 1'b1; tick();
    check("reenable_no_clear", cnt_val, 64'd2);
    repeat (4) tick();
    int_en = 1'b1;
    #1;
    check("pre_rst_cnt", cnt_val, 64'd6);
    check("pre_rst_tim_int", {63'd0, tim_int}, 64'd1);

    // Asynchronous reset mid-count
    #1; sys_rst_n = 1'b0;
    #1;
    check("arst_cnt", cnt_val, 64'd0);
    check("arst_cmp", cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("arst_int_st", {63'd0, int_st}, 64'd0);
    check("arst_tim_int", {63'd0, tim_int}, 64'd0);
    #2; sys_rst_n = 1'b1;
    tick();
    check("resume", cnt_val, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
